// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: drives PC enable/stall, runs the single-outstanding
// instruction-cache handshake, qualifies instructions to decode and handles redirect/halt/timeout.
module fetch_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic        decode_stall,
    output logic        fetch_enable_control,
    output logic        fetch_stall_control,
    output logic        icache_req_valid,
    output logic        instr_valid,
    output logic        fetch_error,
    output logic [31:0] instr_count
);

    localparam int unsigned TMO_W     = 8;
    localparam int unsigned COUNT_W   = 32;
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT,
        S_HOLD,
        S_ERROR
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_drop_pending;
    logic                 w_drop_nxt;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [TMO_W-1:0]     w_tmo_nxt;
    logic [TMO_W-1:0]     w_tmo_inc;
    logic                 w_tmo_hit;
    logic [COUNT_W-1:0]   r_instr_count;
    logic                 w_count_inc;
    logic                 w_req_issue;

    // Saturating age of the outstanding request; hit means this cycle is its last allowed one.
    assign w_tmo_inc = (r_tmo_cnt >= TMO_MAX) ? TMO_MAX : r_tmo_cnt + TMO_W'(1);
    assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_drop_pending <= 1'b0;
            r_tmo_cnt      <= '0;
            r_instr_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_drop_pending <= w_drop_nxt;
            r_tmo_cnt      <= w_tmo_nxt;
            if (w_count_inc) begin
                r_instr_count <= r_instr_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_drop_nxt           = r_drop_pending;
        w_tmo_nxt            = r_tmo_cnt;
        w_count_inc          = 1'b0;
        w_req_issue          = 1'b0;
        fetch_enable_control = 1'b0;
        fetch_stall_control  = 1'b0;
        icache_req_valid     = 1'b0;
        instr_valid          = 1'b0;
        fetch_error          = 1'b0;

        // Outputs stay quiet while reset is held, whatever the inputs do.
        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_enable_control = 1'b1;
                        w_state_nxt          = S_REQUEST;
                    end else if (start) begin
                        w_state_nxt = S_REQUEST;
                    end
                end

                S_REQUEST: begin
                    // A redirect withdraws the request so a same-cycle ready is not a handshake.
                    w_req_issue      = !r_drop_pending && !redirect;
                    icache_req_valid = w_req_issue;
                    if (r_drop_pending) begin
                        if (icache_resp_valid) begin
                            w_drop_nxt = 1'b0;
                        end else begin
                            w_tmo_nxt = w_tmo_inc;
                        end
                    end
                    if (redirect) begin
                        fetch_enable_control = 1'b1;
                    end else if (w_req_issue && icache_req_ready) begin
                        w_state_nxt = S_WAIT;
                        w_tmo_nxt   = '0;
                    end else if (halt) begin
                        w_state_nxt = S_IDLE;
                        w_drop_nxt  = 1'b0;
                    end else if (r_drop_pending && !icache_resp_valid && w_tmo_hit) begin
                        w_state_nxt = S_ERROR;
                    end
                end

                S_WAIT: begin
                    fetch_stall_control = 1'b1;
                    w_tmo_nxt           = w_tmo_inc;
                    if (redirect) begin
                        fetch_enable_control = 1'b1;
                        fetch_stall_control  = 1'b0;
                        w_state_nxt          = S_REQUEST;
                        if (!icache_resp_valid) begin
                            w_drop_nxt = 1'b1;
                        end
                    end else if (icache_resp_valid) begin
                        instr_valid = 1'b1;
                        if (!decode_stall) begin
                            fetch_enable_control = 1'b1;
                            fetch_stall_control  = 1'b0;
                            w_count_inc          = 1'b1;
                            w_state_nxt          = S_REQUEST;
                        end else begin
                            w_state_nxt = S_HOLD;
                        end
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_ERROR;
                    end
                end

                S_HOLD: begin
                    instr_valid         = 1'b1;
                    fetch_stall_control = 1'b1;
                    if (redirect) begin
                        fetch_enable_control = 1'b1;
                        fetch_stall_control  = 1'b0;
                        instr_valid          = 1'b0;
                        w_state_nxt          = S_REQUEST;
                    end else if (!decode_stall) begin
                        fetch_enable_control = 1'b1;
                        fetch_stall_control  = 1'b0;
                        w_count_inc          = 1'b1;
                        w_state_nxt          = S_REQUEST;
                    end
                end

                S_ERROR: begin
                    fetch_error = 1'b1;
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random traffic,
// all compared against a transaction-level model of the fetch sequencing rules.
module tb_fetch_controller;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic        redirect;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic        decode_stall;
    logic        fetch_enable_control;
    logic        fetch_stall_control;
    logic        icache_req_valid;
    logic        instr_valid;
    logic        fetch_error;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fetch_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .halt                 (halt),
        .redirect             (redirect),
        .icache_req_ready     (icache_req_ready),
        .icache_resp_valid    (icache_resp_valid),
        .decode_stall         (decode_stall),
        .fetch_enable_control (fetch_enable_control),
        .fetch_stall_control  (fetch_stall_control),
        .icache_req_valid     (icache_req_valid),
        .instr_valid          (instr_valid),
        .fetch_error          (fetch_error),
        .instr_count          (instr_count)
    );

    always #5 clk = ~clk;

    // Model: is fetching active, is a live request in flight, is an instruction
    // parked for decode, is a stale response owed, how old is the in-flight request.
    bit          m_active, m_inflight, m_held, m_stale, m_err;
    int          m_age;
    logic [31:0] m_count;

    // Output vectors are {enable, stall, req_valid, instr_valid, error}.
    logic [4:0]  exp_o, act_o;
    logic [31:0] exp_cnt, act_cnt;

    function automatic int age_up(input int a);
        return (a >= T) ? T : a + 1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_inflight = 0; m_held = 0; m_stale = 0; m_err = 0;
        m_age = 0; m_count = 32'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
        icache_req_ready = 1'b0; icache_resp_valid = 1'b0; decode_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus v = {start, halt, redirect, ready, resp_valid, decode_stall}.
    task automatic step(input logic [5:0] v);
        bit en, st, rq, iv, er, was_stale;
        int prev_age;
        logic s, h, r, rdy, rv, ds;
        {s, h, r, rdy, rv, ds} = v;
        @(negedge clk);
        start = s; halt = h; redirect = r;
        icache_req_ready = rdy; icache_resp_valid = rv; decode_stall = ds;
        #2;
        en = 0; st = 0; rq = 0; iv = 0; er = 0;
        exp_cnt   = m_count;
        prev_age  = m_age;
        was_stale = m_stale;
        if (m_err) begin
            er = 1;
        end else if (!m_active) begin
            if (r || s) m_active = 1;
            en = r;
        end else if (m_inflight) begin
            st    = 1;
            m_age = age_up(m_age);
            if (r) begin
                en = 1; st = 0; m_inflight = 0;
                if (!rv) m_stale = 1;
            end else if (rv) begin
                iv = 1; m_inflight = 0;
                if (!ds) begin en = 1; st = 0; m_count = m_count + 32'd1; end
                else m_held = 1;
            end else if (prev_age >= T - 1) begin
                m_err = 1;
            end
        end else if (m_held) begin
            iv = 1; st = 1;
            if (r) begin en = 1; st = 0; iv = 0; m_held = 0; end
            else if (!ds) begin en = 1; st = 0; m_held = 0; m_count = m_count + 32'd1; end
        end else begin
            rq = !m_stale && !r;
            if (m_stale) begin
                if (rv) m_stale = 0;
                else m_age = age_up(m_age);
            end
            if (r) en = 1;
            else if (rq && rdy) begin m_inflight = 1; m_age = 0; end
            else if (h) begin m_active = 0; m_stale = 0; end
            else if (was_stale && !rv && prev_age >= T - 1) m_err = 1;
        end
        exp_o   = {en, st, rq, iv, er};
        act_o   = {fetch_enable_control, fetch_stall_control, icache_req_valid, instr_valid, fetch_error};
        act_cnt = instr_count;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b1; start = 1'b1; icache_resp_valid = 1'b1;
        #2;
        act_o = {fetch_enable_control, fetch_stall_control, icache_req_valid, instr_valid, fetch_error};
        if (act_o !== 5'b0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold outs=%b count=%0d expected outs=00000 count=0", act_o, instr_count);
        end
        checks++;
        repeat (2) @(negedge clk);
        rst = 1'b0; redirect = 1'b0; start = 1'b0; icache_resp_valid = 1'b0;
        halt = 1'b0; icache_req_ready = 1'b0; decode_stall = 1'b0;
        model_reset();
        step(6'b000000);
        if (act_o !== 5'b0 || act_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_after outs=%b count=%0d expected outs=00000 count=0", act_o, act_cnt);
        end
        checks++;
    endtask

    task automatic test_stream();
        int pulses;
        logic rv;
        pulses = 0;
        step(6'b100000);
        for (int i = 0; i < 10; i++) begin
            rv = m_inflight;
            step({4'b0001, rv, 1'b0});
            if ({act_o, act_cnt} !== {exp_o, exp_cnt}) begin
                failures++;
                $display("FAIL stream cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", cyc, act_o, act_cnt, exp_o, exp_cnt);
            end
            checks++;
            if (i == 0) begin
                if (act_o[2] !== 1'b1) begin
                    failures++;
                    $display("FAIL first_req req_valid=%b expected 1", act_o[2]);
                end
                checks++;
            end
            pulses += int'(act_o[4]);
        end
        if (pulses != 5) begin
            failures++;
            $display("FAIL stream_pulses got=%0d expected 5", pulses);
        end
        checks++;
        step(6'b000000);
        if (act_cnt !== 32'd5) begin
            failures++;
            $display("FAIL stream_count got=%0d expected 5", act_cnt);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [5:0] seq [5];
        int ivs, ens, stalls;
        logic [31:0] base;
        seq = '{6'b000100, 6'b000011, 6'b000001, 6'b000001, 6'b000000};
        ivs = 0; ens = 0; stalls = 0;
        base = m_count;
        for (int i = 0; i < 5; i++) begin
            step(seq[i]);
            if ({act_o, act_cnt} !== {exp_o, exp_cnt}) begin
                failures++;
                $display("FAIL backpressure cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", cyc, act_o, act_cnt, exp_o, exp_cnt);
            end
            checks++;
            if (i >= 1) begin
                ivs += int'(act_o[1]);
                ens += int'(act_o[4]);
            end
            if (i >= 1 && i <= 3) stalls += int'(act_o[3]);
        end
        if (ivs != 4 || ens != 1 || stalls != 3) begin
            failures++;
            $display("FAIL backpressure_shape iv=%0d en=%0d stall=%0d expected 4 1 3", ivs, ens, stalls);
        end
        checks++;
        step(6'b000000);
        if (act_cnt !== base + 32'd1) begin
            failures++;
            $display("FAIL backpressure_count got=%0d expected %0d", act_cnt, base + 32'd1);
        end
        checks++;
    endtask

    task automatic test_redirect_wait();
        logic [5:0] seq [8];
        seq = '{6'b000100, 6'b001000, 6'b000100, 6'b000100, 6'b000110,
                6'b000100, 6'b001010, 6'b000000};
        for (int i = 0; i < 8; i++) begin
            step(seq[i]);
            if ({act_o, act_cnt} !== {exp_o, exp_cnt}) begin
                failures++;
                $display("FAIL redirect cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", cyc, act_o, act_cnt, exp_o, exp_cnt);
            end
            checks++;
            if (i == 1 && act_o[4:3] !== 2'b10) begin
                failures++;
                $display("FAIL redirect_enable en_stall=%b expected 10", act_o[4:3]);
            end
            if (i == 2 && (dut.r_drop_pending !== 1'b1 || act_o[2] !== 1'b0)) begin
                failures++;
                $display("FAIL drop_set drop=%b req=%b expected drop=1 req=0", dut.r_drop_pending, act_o[2]);
            end
            if (i == 4 && act_o[2:1] !== 2'b00) begin
                failures++;
                $display("FAIL stale_resp req_iv=%b expected 00", act_o[2:1]);
            end
            if (i == 5 && act_o[2] !== 1'b1) begin
                failures++;
                $display("FAIL reissue req=%b expected 1", act_o[2]);
            end
            if (i == 6 && act_o[4:1] !== 4'b1000) begin
                failures++;
                $display("FAIL redirect_resp en_stall_req_iv=%b expected 1000", act_o[4:1]);
            end
            if (i == 7 && (dut.r_drop_pending !== 1'b0 || act_o[2] !== 1'b1)) begin
                failures++;
                $display("FAIL no_drop drop=%b req=%b expected drop=0 req=1", dut.r_drop_pending, act_o[2]);
            end
            if (i == 1 || i == 2 || i == 4 || i == 5 || i == 6 || i == 7) checks++;
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        step(6'b100000);
        step(6'b000100);
        for (int i = 1; i <= 5; i++) begin
            step(6'b000000);
            if (act_o[0] !== ((i == 5) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL timeout cycle=%0d error=%b expected %b", i, act_o[0], (i == 5));
            end
            checks++;
        end
        for (int i = 0; i < 20; i++) begin
            step(6'($urandom));
            if (act_o !== 5'b00001) begin
                failures++;
                $display("FAIL error_sticky cyc=%0d outs=%b expected 00001", cyc, act_o);
            end
            checks++;
        end
        apply_reset();
        step(6'b000000);
        if (act_o !== 5'b00000) begin
            failures++;
            $display("FAIL error_clear outs=%b expected 00000", act_o);
        end
        checks++;
    endtask

    task automatic test_halt_events();
        logic [5:0] seq [9];
        logic [4:0] want;
        seq = '{6'b100000, 6'b010000, 6'b000000, 6'b100000, 6'b010100,
                6'b000000, 6'b000010, 6'b011100, 6'b000000};
        for (int i = 0; i < 9; i++) begin
            step(seq[i]);
            if ({act_o, act_cnt} !== {exp_o, exp_cnt}) begin
                failures++;
                $display("FAIL halt cyc=%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", cyc, act_o, act_cnt, exp_o, exp_cnt);
            end
            checks++;
            case (i)
                2: want = 5'b00000;
                5: want = 5'b01000;
                7: want = 5'b10000;
                8: want = 5'b00100;
                default: want = act_o;
            endcase
            if (i == 2 || i == 5 || i == 7 || i == 8) begin
                if (act_o !== want) begin
                    failures++;
                    $display("FAIL halt_point step=%0d outs=%b expected %b", i, act_o, want);
                end
                checks++;
            end
        end
    endtask

    task automatic test_wrap_async_reset();
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        m_count = 32'hFFFF_FFFF;
        step(6'b000100);
        step(6'b000010);
        step(6'b000000);
        if (act_cnt !== 32'd0 || exp_cnt !== act_cnt) begin
            failures++;
            $display("FAIL count_wrap got=%h expected 00000000", act_cnt);
        end
        checks++;
        step(6'b000100);
        step(6'b000000);
        rst = 1'b1;
        #1;
        act_o = {fetch_enable_control, fetch_stall_control, icache_req_valid, instr_valid, fetch_error};
        if (act_o !== 5'b0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL async_reset outs=%b count=%0d expected 00000 0", act_o, instr_count);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(6'b000010);
        if (act_o !== 5'b0 || exp_o !== act_o) begin
            failures++;
            $display("FAIL late_resp outs=%b expected 00000", act_o);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [5:0] v;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v[5] = ($urandom_range(0, 3) == 0);
            v[4] = ($urandom_range(0, 15) == 0);
            v[3] = ($urandom_range(0, 19) == 0);
            v[2] = ($urandom_range(0, 9) < 7);
            v[1] = ($urandom_range(0, 9) < 5);
            v[0] = ($urandom_range(0, 9) < 3);
            step(v);
            if ({act_o, act_cnt} !== {exp_o, exp_cnt}) begin
                failures++;
                $display("FAIL random cyc=%0d in=%b outs=%b cnt=%0d expected outs=%b cnt=%0d", cyc, v, act_o, act_cnt, exp_o, exp_cnt);
            end
            checks++;
            if (m_err && $urandom_range(0, 3) == 0) apply_reset();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
        icache_req_ready = 1'b0; icache_resp_valid = 1'b0; decode_stall = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_timeout();
        test_halt_events();
        test_wrap_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time budget expired checks=%0d", checks);
        $fatal(1);
    end

endmodule
